div_ctrl: RTL and testbench

- Sequencing controller for the shared 32-bit iterative divider that serves div.w, div.wu, mod.w and mod.wu.
- Accepts a request from the execute stage and runs a restoring divide, one quotient bit per cycle.
- Applies sign fix-up, then holds quotient and remainder stable on div_result and mod_result, which the memory stage selects. Results stay stable until the execute stage acknowledges and the next request is accepted.
- Execute stage uses div_done as its ready_go for divide ops; flush (excp_flush | ertn_flush) aborts an in-flight divide.

---
 rtl/div_ctrl_pkg.sv | 22 ++
 rtl/div_restoring_step.sv | 29 ++
 rtl/div_ctrl.sv | 141 ++++++++++++++
 tb/tb_div_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative 32-bit divider controller:
// FSM state encodings, datapath widths, nominal latency and a negate helper.
package div_ctrl_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = 5;
  // Cycles from the accept cycle to the first cycle with div_done=1.
  localparam int unsigned DIV_LAT   = 34;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_RUN  = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_e;

  // Two's-complement negate.
  function automatic logic [DIV_W-1:0] div_neg(input logic [DIV_W-1:0] x);
    return (~x) + DIV_W'(1);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step (combinational).
//   rem_i     : partial remainder before the step
//   divisor_i : divisor magnitude
//   dvd_bit_i : next dividend bit, MSB first
//   rem_o     : partial remainder after the step
//   q_bit_o   : quotient bit produced by the step
module div_restoring_step
  import div_ctrl_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] divisor_i,
  input  logic         dvd_bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] shifted;

  // Compare at W+1 bits so the remainder MSB shifted out is not lost
  // when an unsigned divisor has its top bit set.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? W'(shifted - {1'b0, divisor_i}) : W'(shifted);
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the shared iterative divider
// (div.w / div.wu / mod.w / mod.wu).
//   clk, reset              : clock, synchronous active-high reset
//   flush                   : aborts any in-flight operation
//   div_req, div_signed     : request level and signedness from execute
//   div_src1, div_src2      : dividend, divisor (captured at accept only)
//   div_ack                 : execute moved the op to memory stage
//   div_busy, div_done      : controller not idle / results valid
//   div_result, mod_result  : quotient and remainder, held until next write
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = DIV_W,
  parameter bit          FAST_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              div_req,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  input  logic              div_ack,
  output logic              div_busy,
  output logic              div_done,
  output logic [DATA_W-1:0] div_result,
  output logic [DATA_W-1:0] mod_result
);

  div_state_e           state_q;
  logic                 busy_q, done_q;
  logic [DATA_W-1:0]    div_q, mod_q;
  logic [DATA_W-1:0]    rem_q, dvd_q, dsr_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 sgn_q, a_neg_q, b_neg_q, zero_q;

  logic [DATA_W-1:0]    rem_d, quo_fix_d, rem_fix_d;
  logic                 q_bit_d;
  logic [DATA_W-1:0]    src1_mag, src2_mag;

  // Operand magnitudes; only signed ops take absolute values.
  assign src1_mag = (div_signed && div_src1[DATA_W-1]) ? div_neg(div_src1) : div_src1;
  assign src2_mag = (div_signed && div_src2[DATA_W-1]) ? div_neg(div_src2) : div_src2;

  div_restoring_step #(.W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dsr_q),
    .dvd_bit_i (dvd_q[DATA_W-1]),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  // Sign fix-up. With a zero divisor the iteration leaves rem = |src1|, so
  // the normal remainder fix-up already restores raw src1; only the
  // quotient needs forcing.
  always_comb begin
    quo_fix_d = dvd_q;
    rem_fix_d = rem_q;
    if (sgn_q && (a_neg_q ^ b_neg_q)) quo_fix_d = div_neg(dvd_q);
    if (sgn_q && a_neg_q)             rem_fix_d = div_neg(rem_q);
    if (zero_q)                       quo_fix_d = '1;
  end

  // FSM, counter, operand registers and result registers.
  // dvd_q shifts the dividend out MSB-first and the quotient in LSB-first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      mod_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (flush) begin
      state_q <= DIV_ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          if (div_req) begin
            sgn_q   <= div_signed;
            a_neg_q <= div_signed & div_src1[DATA_W-1];
            b_neg_q <= div_signed & div_src2[DATA_W-1];
            zero_q  <= (div_src2 == '0);
            dvd_q   <= src1_mag;
            dsr_q   <= src2_mag;
            rem_q   <= '0;
            cnt_q   <= DIV_CNT_W'(DATA_W - 1);
            busy_q  <= 1'b1;
            if (FAST_ZERO && (div_src2 == '0)) begin
              state_q <= DIV_ST_DONE;
              done_q  <= 1'b1;
              div_q   <= '1;
              mod_q   <= div_src1;
            end else begin
              state_q <= DIV_ST_RUN;
            end
          end
        end
        DIV_ST_RUN: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[DATA_W-2:0], q_bit_d};
          cnt_q <= cnt_q - DIV_CNT_W'(1);
          if (cnt_q == '0) state_q <= DIV_ST_FIX;
        end
        DIV_ST_FIX: begin
          div_q   <= quo_fix_d;
          mod_q   <= rem_fix_d;
          done_q  <= 1'b1;
          state_q <= DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          if (div_ack) begin
            state_q <= DIV_ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_busy   = busy_q;
  assign div_done   = done_q;
  assign div_result = div_q;
  assign mod_result = mod_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: two instances (FAST_ZERO=1 and FAST_ZERO=0) sharing
// operands, each with its own req/ack, checked every cycle against a
// transaction-level model plus hand-computed literal expectations.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, div_signed;
  logic [31:0] src1, src2;
  logic        req  [2];
  logic        ack  [2];
  logic        busy [2];
  logic        done [2];
  logic [31:0] divr [2];
  logic [31:0] modr [2];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  div_ctrl #(.DATA_W(32), .FAST_ZERO(1'b1)) u_fast (
    .clk(clk), .reset(reset), .flush(flush), .div_req(req[0]),
    .div_signed(div_signed), .div_src1(src1), .div_src2(src2),
    .div_ack(ack[0]), .div_busy(busy[0]), .div_done(done[0]),
    .div_result(divr[0]), .mod_result(modr[0]));

  div_ctrl #(.DATA_W(32), .FAST_ZERO(1'b0)) u_slow (
    .clk(clk), .reset(reset), .flush(flush), .div_req(req[1]),
    .div_signed(div_signed), .div_src1(src1), .div_src2(src2),
    .div_ack(ack[1]), .div_busy(busy[1]), .div_done(done[1]),
    .div_result(divr[1]), .mod_result(modr[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating division, remainder takes dividend sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Transaction model: accept -> results visible after fixed latency,
  // held until ack; flush/reset abort.
  localparam bit FZ [2] = '{1'b1, 1'b0};
  bit          m_busy [2];
  bit          m_done [2];
  logic [31:0] m_div  [2];
  logic [31:0] m_mod  [2];
  logic [31:0] p_div  [2];
  logic [31:0] p_mod  [2];
  int          m_cnt  [2];
  logic [31:0] mq, mr;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0;
        m_div[i]  = '0;   m_mod[i]  = '0;  m_cnt[i] = 0;
      end else if (flush) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end else if (!m_busy[i]) begin
        if (req[i]) begin
          ref_div(src1, src2, div_signed, mq, mr);
          m_busy[i] = 1'b1;
          p_div[i]  = mq;
          p_mod[i]  = mr;
          if (FZ[i] && src2 == 32'd0) begin
            m_done[i] = 1'b1; m_div[i] = mq; m_mod[i] = mr;
          end else begin
            m_cnt[i] = int'(DIV_LAT) - 1;
          end
        end
      end else if (!m_done[i]) begin
        if (m_cnt[i] == 1) begin
          m_done[i] = 1'b1; m_div[i] = p_div[i]; m_mod[i] = p_mod[i];
        end
        m_cnt[i] = m_cnt[i] - 1;
      end else if (ack[i]) begin
        m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
        check($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
        check($sformatf("div%0d", i),  divr[i], m_div[i]);
        check($sformatf("mod%0d", i),  modr[i], m_mod[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s);
    src1 = a; src2 = b; div_signed = s; req[idx] = 1'b1;
    step();
    req[idx] = 1'b0;
    check("busy_after_accept", 32'(busy[idx]), 32'd1);
  endtask

  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (done[idx] === 1'b1) break;
      if (lat >= 100) begin
        check("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic do_ack(input int idx);
    step(); ack[idx] = 1'b1;
    step(); ack[idx] = 1'b0;
  endtask

  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int exp_lat, input logic [31:0] eq,
                        input logic [31:0] er, input string name);
    int lat;
    start(idx, a, b, s);
    wait_done(idx, lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_q"}, divr[idx], eq);
    check({name, "_r"}, modr[idx], er);
    do_ack(idx);
  endtask

  int lat;

  initial begin
    reset = 1'b1; flush = 1'b0; div_signed = 1'b0; src1 = '0; src2 = '0;
    req[0] = 1'b0; req[1] = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
    step();
    chk_en = 1'b1;
    step(); step();
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_div",  divr[0], 32'd0);
    check("rst_mod",  modr[0], 32'd0);
    reset = 1'b0;
    step();

    run_op(0, 32'd7,          32'd2,          1'b0, 34, 32'd3,          32'd1,          "u7_2");
    run_op(0, 32'hFFFF_FFF9,  32'd2,          1'b1, 34, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  "sm7_2");
    run_op(0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 34, 32'h8000_0000,  32'd0,          "ovf");
    run_op(0, 32'h1234_5678,  32'd0,          1'b0, 1,  32'hFFFF_FFFF,  32'h1234_5678,  "z_fast");
    run_op(1, 32'h1234_5678,  32'd0,          1'b0, 34, 32'hFFFF_FFFF,  32'h1234_5678,  "z_slow");
    run_op(0, 32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 34, 32'd1,          32'h7FFF_FFFE,  "u_big");
    run_op(0, 32'd7,          32'hFFFF_FFFE,  1'b1, 34, 32'hFFFF_FFFD,  32'd1,          "s7_m2");
    run_op(0, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 34, 32'd3,          32'hFFFF_FFFF,  "sm7_m2");
    run_op(0, 32'h8000_0000,  32'd0,          1'b1, 1,  32'hFFFF_FFFF,  32'h8000_0000,  "z_fast_s");
    run_op(1, 32'hFFFF_FFF9,  32'd0,          1'b1, 34, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  "z_slow_s");
    run_op(0, 32'd100,        32'd7,          1'b0, 34, 32'd14,         32'd2,          "u100_7");

    // Flush mid-RUN at T+10, new request at T+11.
    start(0, 32'd1000, 32'd3, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 32'(busy[0]), 32'd0);
    check("flush_done", 32'(done[0]), 32'd0);
    check("flush_div",  divr[0], 32'd14);
    check("flush_mod",  modr[0], 32'd2);
    start(0, 32'd1000, 32'd3, 1'b0);
    wait_done(0, lat);
    check("reacc_lat", 32'(lat), 32'd34);
    check("reacc_q", divr[0], 32'd333);
    check("reacc_r", modr[0], 32'd1);
    do_ack(0);

    // Ack withheld 5 cycles; req in the ack cycle must be ignored.
    start(0, 32'd50, 32'd6, 1'b0);
    wait_done(0, lat);
    check("hold_lat", 32'(lat), 32'd34);
    repeat (5) step();
    check("hold_done", 32'(done[0]), 32'd1);
    check("hold_q", divr[0], 32'd8);
    check("hold_r", modr[0], 32'd2);
    ack[0] = 1'b1; req[0] = 1'b1; src1 = 32'd9; src2 = 32'd4; div_signed = 1'b0;
    step();
    ack[0] = 1'b0;
    check("ackcyc_busy", 32'(busy[0]), 32'd0);
    check("ackcyc_q", divr[0], 32'd8);
    step();
    req[0] = 1'b0;
    check("postack_busy", 32'(busy[0]), 32'd1);
    wait_done(0, lat);
    check("postack_lat", 32'(lat), 32'd34);
    check("postack_q", divr[0], 32'd2);
    check("postack_r", modr[0], 32'd1);
    do_ack(0);

    // Flush together with req in IDLE: no accept.
    flush = 1'b1; req[0] = 1'b1; src1 = 32'd5; src2 = 32'd1;
    step();
    flush = 1'b0; req[0] = 1'b0;
    check("flreq_busy", 32'(busy[0]), 32'd0);
    step();
    check("flreq_busy2", 32'(busy[0]), 32'd0);

    // Flush together with ack in DONE.
    start(0, 32'd5, 32'd1, 1'b0);
    wait_done(0, lat);
    step();
    flush = 1'b1; ack[0] = 1'b1;
    step();
    flush = 1'b0; ack[0] = 1'b0;
    check("flack_done", 32'(done[0]), 32'd0);
    check("flack_busy", 32'(busy[0]), 32'd0);
    check("flack_q", divr[0], 32'd5);

    // Flush in the FIX cycle (T+33): results must not be written.
    start(0, 32'd40, 32'd3, 1'b0);
    repeat (32) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flfix_busy", 32'(busy[0]), 32'd0);
    check("flfix_q", divr[0], 32'd5);
    check("flfix_r", modr[0], 32'd0);
    repeat (3) step();
    check("flfix_done", 32'(done[0]), 32'd0);

    // Reset mid-operation discards progress and clears results.
    start(0, 32'd40, 32'd3, 1'b0);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_busy", 32'(busy[0]), 32'd0);
    check("rstmid_q", divr[0], 32'd0);
    check("rstmid_r", modr[0], 32'd0);
    run_op(0, 32'd40, 32'd3, 1'b0, 34, 32'd13, 32'd1, "u40_3");

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
